// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage: instruction-fetch stage of the 5-stage pipeline.
// Owns the PC, drives the combinational instruction-memory address and
// registers the fetched word into the IF/ID pipeline register. Branch and
// jump redirects take priority over stall; flush/redirect squash IF/ID.
// Optional feature macro: IF_PERF_CNT_EN adds fetch_cnt / stall_cnt
// performance counters (ports and logic absent when undefined).
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned XLEN = 32;

    // Per-cycle operating mode of the stage
    typedef enum logic [1:0] {
        MODE_RUN  = 2'd0,
        MODE_HOLD = 2'd1,
        MODE_KILL = 2'd2
    } mode_e;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_next_pc;
    logic            w_kill;
    mode_e           w_mode;

    assign im_addr = r_pc;
    assign w_pc4   = r_pc + XLEN'(4);
    assign w_kill  = flush | br_taken | jmp;

    // Decode the cycle mode: any redirect or flush kills, otherwise stall holds
    always_comb begin
        w_mode = MODE_RUN;
        if (w_kill) begin
            w_mode = MODE_KILL;
        end else if (stall) begin
            w_mode = MODE_HOLD;
        end
    end

    // Next-PC selection: branch beats jump beats stall; targets aligned down to a word
    always_comb begin
        w_next_pc = w_pc4;
        if (br_taken) begin
            w_next_pc = {br_target[XLEN-1:2], 2'b00};
        end else if (jmp) begin
            w_next_pc = {jmp_target[XLEN-1:2], 2'b00};
        end else if (stall) begin
            w_next_pc = r_pc;
        end
    end

    // Program counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // IF/ID pipeline register: bubble on kill, hold on stall, load otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_instr <= NOP_INSTR;
            id_pc4   <= XLEN'(0);
            id_valid <= 1'b0;
        end else begin
            case (w_mode)
                MODE_KILL: begin
                    id_instr <= NOP_INSTR;
                    id_pc4   <= XLEN'(0);
                    id_valid <= 1'b0;
                end
                MODE_HOLD: begin
                    id_instr <= id_instr;
                    id_pc4   <= id_pc4;
                    id_valid <= id_valid;
                end
                default: begin
                    id_instr <= im_data;
                    id_pc4   <= w_pc4;
                    id_valid <= 1'b1;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    // Performance counters: delivered instructions and stalled cycles, both wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= XLEN'(0);
            stall_cnt <= XLEN'(0);
        end else begin
            if (w_mode == MODE_RUN) begin
                fetch_cnt <= fetch_cnt + XLEN'(1);
            end
            if (stall) begin
                stall_cnt <= stall_cnt + XLEN'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage: self-checking bench for if_stage. Directed scenarios followed by
// randomized control traffic compared against a cycle-level reference model.
// Counter checks are active when IF_PERF_CNT_EN is defined.
// ----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int total;
    int bad;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_fcnt;
    logic [31:0] m_scnt;

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .im_addr    (im_addr),
        .im_data    (im_data),
        .stall      (stall),
        .flush      (flush),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .id_instr   (id_instr),
        .id_pc4     (id_pc4),
        .id_valid   (id_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    // instruction memory contents: word at a is 0x2010_0000 + (index << 16)
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2010_0000 + (a << 14);
    endfunction

    assign im_data = mem_word(im_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // apply reset for one clock and reset the model
    task automatic reset_dut();
        stall = 0; flush = 0; br_taken = 0; jmp = 0;
        br_target = '0; jmp_target = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
        m_fcnt = 32'h0; m_scnt = 32'h0;
    endtask

    // drive one cycle of controls, advance the model by the stated rules, settle
    task automatic cycle(input logic st, input logic fl, input logic bt,
                         input logic [31:0] btgt, input logic j, input logic [31:0] jtgt);
        logic        kill;
        logic [31:0] npc;
        stall = st; flush = fl; br_taken = bt; br_target = btgt;
        jmp = j; jmp_target = jtgt;
        @(posedge clk);
        kill = fl | bt | j;
        if (bt)      npc = btgt & 32'hFFFF_FFFC;
        else if (j)  npc = jtgt & 32'hFFFF_FFFC;
        else if (st) npc = m_pc;
        else         npc = m_pc + 32'd4;
        if (kill) begin
            m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
            m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_fcnt = m_fcnt + 32'd1;
        end
        if (st) m_scnt = m_scnt + 32'd1;
        m_pc = npc;
        #1;
        stall = 0; flush = 0; br_taken = 0; jmp = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        total++; if (im_addr !== 32'h0) begin bad++; $display("FAIL reset_im_addr got=%h exp=%h", im_addr, 32'h0); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        total++; if (id_instr !== NOP) begin bad++; $display("FAIL reset_id_instr got=%h exp=%h", id_instr, NOP); end
        total++; if (id_pc4 !== 32'h0) begin bad++; $display("FAIL reset_id_pc4 got=%h exp=0", id_pc4); end
`ifdef IF_PERF_CNT_EN
        total++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin bad++; $display("FAIL reset_counters got=%h/%h exp=0/0", fetch_cnt, stall_cnt); end
`endif
    endtask

    task automatic test_sequential();
        cycle(0, 0, 0, '0, 0, '0);
        total++; if (id_instr !== 32'h2010_0000) begin bad++; $display("FAIL seq_id_instr got=%h exp=20100000", id_instr); end
        total++; if (id_pc4 !== 32'h4) begin bad++; $display("FAIL seq_id_pc4 got=%h exp=4", id_pc4); end
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL seq_id_valid got=%b exp=1", id_valid); end
        total++; if (im_addr !== 32'h4) begin bad++; $display("FAIL seq_im_addr got=%h exp=4", im_addr); end
    endtask

    task automatic test_stall();
        cycle(0, 0, 0, '0, 0, '0);
        for (int k = 0; k < 2; k++) begin
            cycle(1, 0, 0, '0, 0, '0);
            total++; if (im_addr !== 32'h8) begin bad++; $display("FAIL stall_im_addr[%0d] got=%h exp=8", k, im_addr); end
            total++; if (id_instr !== 32'h2011_0000 || id_pc4 !== 32'h8) begin
                bad++; $display("FAIL stall_ifid[%0d] got=%h/%h exp=20110000/8", k, id_instr, id_pc4); end
        end
        cycle(0, 0, 0, '0, 0, '0);
        total++; if (id_instr !== 32'h2012_0000 || id_pc4 !== 32'hC) begin
            bad++; $display("FAIL stall_release_ifid got=%h/%h exp=20120000/c", id_instr, id_pc4); end
        total++; if (im_addr !== 32'hC) begin bad++; $display("FAIL stall_release_im_addr got=%h exp=c", im_addr); end
    endtask

    task automatic test_jump();
        for (int k = 0; k < 6; k++) cycle(0, 0, 0, '0, 0, '0);
        total++; if (im_addr !== 32'h24) begin bad++; $display("FAIL jump_pre_pc got=%h exp=24", im_addr); end
        cycle(0, 0, 0, '0, 1, 32'h10);
        total++; if (im_addr !== 32'h10) begin bad++; $display("FAIL jump_im_addr got=%h exp=10", im_addr); end
        total++; if (id_valid !== 1'b0 || id_instr !== NOP) begin
            bad++; $display("FAIL jump_squash got=%b/%h exp=0/%h", id_valid, id_instr, NOP); end
    endtask

    task automatic test_redirect_priority();
        cycle(1, 0, 1, 32'h24, 1, 32'h10);
        total++; if (im_addr !== 32'h24) begin bad++; $display("FAIL prio_im_addr got=%h exp=24", im_addr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL prio_id_valid got=%b exp=0", id_valid); end
        cycle(0, 1, 0, '0, 0, '0);
        total++; if (im_addr !== 32'h28 || id_valid !== 1'b0) begin
            bad++; $display("FAIL flush_only got=%h/%b exp=28/0", im_addr, id_valid); end
    endtask

    task automatic test_wrap_align();
        cycle(0, 0, 0, '0, 1, 32'hFFFF_FFFC);
        total++; if (im_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pre got=%h exp=fffffffc", im_addr); end
        cycle(0, 0, 0, '0, 0, '0);
        total++; if (im_addr !== 32'h0) begin bad++; $display("FAIL wrap_im_addr got=%h exp=0", im_addr); end
        total++; if (id_pc4 !== 32'h0 || id_valid !== 1'b1) begin
            bad++; $display("FAIL wrap_id_pc4 got=%h/%b exp=0/1", id_pc4, id_valid); end
        cycle(0, 0, 1, 32'h13, 0, '0);
        total++; if (im_addr !== 32'h10) begin bad++; $display("FAIL align_br got=%h exp=10", im_addr); end
        cycle(0, 0, 0, '0, 1, 32'h2B);
        total++; if (im_addr !== 32'h28) begin bad++; $display("FAIL align_jmp got=%h exp=28", im_addr); end
    endtask

    task automatic test_random();
        logic st, fl, bt, j;
        for (int k = 0; k < 400; k++) begin
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            bt = ($urandom_range(0, 9) == 0);
            j  = ($urandom_range(0, 9) == 0);
            cycle(st, fl, bt, $urandom, j, $urandom);
            total++;
            if (im_addr !== m_pc || id_instr !== m_instr || id_pc4 !== m_pc4 || id_valid !== m_valid) begin
                bad++;
                $display("FAIL rand[%0d] got=%h/%h/%h/%b exp=%h/%h/%h/%b", k,
                         im_addr, id_instr, id_pc4, id_valid, m_pc, m_instr, m_pc4, m_valid);
            end
`ifdef IF_PERF_CNT_EN
            total++;
            if (fetch_cnt !== m_fcnt || stall_cnt !== m_scnt) begin
                bad++;
                $display("FAIL rand_cnt[%0d] got=%h/%h exp=%h/%h", k, fetch_cnt, stall_cnt, m_fcnt, m_scnt);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        for (int k = 0; k < 7; k++) cycle(0, 0, 0, '0, 0, '0);
        total++; if (im_addr !== 32'h1C || id_valid !== 1'b1) begin
            bad++; $display("FAIL async_pre got=%h/%b exp=1c/1", im_addr, id_valid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (im_addr !== 32'h0) begin bad++; $display("FAIL async_im_addr got=%h exp=0", im_addr); end
        total++; if (id_valid !== 1'b0 || id_instr !== NOP || id_pc4 !== 32'h0) begin
            bad++; $display("FAIL async_ifid got=%b/%h/%h exp=0/%h/0", id_valid, id_instr, id_pc4, NOP); end
`ifdef IF_PERF_CNT_EN
        total++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
            bad++; $display("FAIL async_counters got=%h/%h exp=0/0", fetch_cnt, stall_cnt); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        stall = 0; flush = 0; br_taken = 0; jmp = 0;
        br_target = '0; jmp_target = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_redirect_priority();
        test_wrap_align();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
